// File: rtl/dram_frame_sequencer_if.sv
// Bundle of the parallel I/O vectors and the 1-bit RAM port seen by dram_frame_sequencer.
// The slave modport is the sequencer side; master is the board/RAM environment side.
interface dram_frame_sequencer_if #(
    parameter int IO_WIDTH   = 16,
    parameter int ADDR_WIDTH = 5
);
    logic [IO_WIDTH-1:0]   in;
    logic                  swap_req;
    logic [IO_WIDTH-1:0]   out;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_bank;
    logic                  ram_we;
    logic                  ram_din;
    logic                  ram_dout;
    logic                  frame_done;
    logic                  disp_bank;

    modport master (
        output in, swap_req, ram_dout,
        input  out, ram_addr, ram_bank, ram_we, ram_din, frame_done, disp_bank
    );

    modport slave (
        input  in, swap_req, ram_dout,
        output out, ram_addr, ram_bank, ram_we, ram_din, frame_done, disp_bank
    );
endinterface

// File: rtl/dram_frame_sequencer.sv
// Double-buffers a parallel vector through a 1-bit single-port RAM: serial write of the
// hidden bank, serial readback of the displayed bank, optional bank swap once per frame.
//
// state     | meaning
// CAPTURE   | latch input vector into shadow
// WRITE     | shadow bits -> hidden bank, one per cycle
// READ      | displayed bank bits -> accumulator, one per cycle
// COMMIT    | publish accumulator, apply pending swap
module dram_frame_sequencer #(
    parameter int IO_WIDTH   = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dram_frame_sequencer_if.slave bus
);

    generate
        if (IO_WIDTH > (2 ** ADDR_WIDTH)) begin : g_bad_width
            $error("IO_WIDTH does not fit in 2**ADDR_WIDTH bank addresses");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [IO_WIDTH-1:0]   r_shadow;
    logic [IO_WIDTH-1:0]   r_acc;
    logic [IO_WIDTH-1:0]   r_out;
    logic                  r_disp;
    logic                  r_swap_pend;
    logic                  w_last;
    logic [IO_WIDTH-1:0]   w_mask;

    assign w_last = (r_cnt == ADDR_WIDTH'(IO_WIDTH - 1));
    // One-hot select of the current bit; avoids an index wider than the vector.
    assign w_mask = IO_WIDTH'(1) << r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.ram_we     = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_bank   = r_disp;
        bus.ram_din    = 1'b0;
        bus.frame_done = 1'b0;
        case (r_state)
            S_CAPTURE: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = r_cnt;
                bus.ram_bank = ~r_disp;
                bus.ram_din  = |(r_shadow & w_mask);
                if (w_last) w_next = S_READ;
            end
            S_READ: begin
                bus.ram_addr = r_cnt;
                if (w_last) w_next = S_COMMIT;
            end
            S_COMMIT: begin
                bus.frame_done = 1'b1;
                w_next         = S_CAPTURE;
            end
            default: w_next = S_CAPTURE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_disp      <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            if ((r_state == S_WRITE) || (r_state == S_READ)) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == S_CAPTURE) r_shadow <= bus.in;

            if (r_state == S_READ) begin
                r_acc <= bus.ram_dout ? (r_acc | w_mask) : (r_acc & ~w_mask);
            end

            // A request arriving in COMMIT is held for the next frame, not merged into this swap.
            if (r_state == S_COMMIT) begin
                r_out       <= r_acc;
                r_disp      <= r_disp ^ r_swap_pend;
                r_swap_pend <= bus.swap_req;
            end else begin
                r_swap_pend <= r_swap_pend | bus.swap_req;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.disp_bank = r_disp;

endmodule

// File: doc/dram_frame_sequencer.md
# dram_frame_sequencer

Time-multiplexing controller for a single-port, 1-bit-wide distributed RAM, such as a RAM64X1S, that double-buffers a parallel input vector. Each frame it:
- writes the captured input bits serially into the hidden bank;
- reads the displayed bank back serially into a parallel output register;
- optionally swaps the two banks.

It sits between board-level switch/LED vectors and the RAM primitive, replacing ad-hoc address shifters in the dram test designs.

## Interface
Parameters:
- IO_WIDTH, 16, width of the parallel input/output vectors and number of RAM bits used per bank
- ADDR_WIDTH, 5, width of the in-bank bit address; IO_WIDTH <= 2**ADDR_WIDTH is required, with elaboration-time check

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in  input  IO_WIDTH  parallel data to store
- swap_req  input  1  single-cycle request to swap displayed/hidden banks
- out  output  IO_WIDTH  registered parallel readback of displayed bank
- ram_addr  output  ADDR_WIDTH  in-bank bit address to RAM
- ram_bank  output  1  bank-select address bit to RAM (MSB of RAM address)
- ram_we  output  1  RAM write enable
- ram_din  output  1  RAM write data
- ram_dout  input  1  RAM asynchronous read data for current address
- frame_done  output  1  one-cycle pulse when out is updated
- disp_bank  output  1  bank currently displayed

## Operation
- The RAM is single-port with asynchronous read and synchronous write on clk.
- The hidden (write) bank is always ~disp_bank.
- The RAM outputs are combinational decodes of the state/counter registers; no extra pipeline stage.
- FSM states, with cnt counting 0..IO_WIDTH-1:
  - CAPTURE (1 cycle): shadow <= in. ram_we=0, ram_addr=0, ram_bank=disp_bank.
  - WRITE (IO_WIDTH cycles): ram_addr=cnt, ram_bank=~disp_bank, ram_we=1, ram_din=shadow[cnt]. After cnt=IO_WIDTH-1, go to READ with cnt=0.
  - READ (IO_WIDTH cycles): ram_addr=cnt, ram_bank=disp_bank, ram_we=0. On each edge, acc[cnt] <= ram_dout. After cnt=IO_WIDTH-1, go to COMMIT.
  - COMMIT (1 cycle): ram_we=0. On the exiting edge:
    - out <= acc, frame_done pulses during this cycle;
    - if swap_pend is set, disp_bank toggles and swap_pend clears;
    - go to CAPTURE.
- swap_req handling:
  - swap_req high in any cycle other than COMMIT sets swap_pend.
  - Multiple requests within one frame collapse into one swap.
  - swap_req high during COMMIT is not lost: it sets swap_pend after the current frame's swap decision, so it applies at the next COMMIT.
- RAM addresses IO_WIDTH..2**ADDR_WIDTH-1 are never accessed.
- The in input is sampled only in CAPTURE; changes at other times affect the next frame.

## Timing
- Frame length is 2*IO_WIDTH+2 cycles (34 for default).
- Reset values (asynchronous assertion, synchronous release):
  - state=CAPTURE, cnt=0, shadow=0, acc=0, out=0;
  - disp_bank=0, swap_pend=0, frame_done=0;
  - ram_we=0, ram_addr=0, ram_bank=0, ram_din=0.
- First frame after reset release: CAPTURE on cycle 0, WRITE cycles 1..16, READ cycles 17..32, COMMIT cycle 33. out is valid after the edge ending cycle 33.
- Latency from in (sampled in CAPTURE) to out:
  - without swap, the data is never displayed;
  - with swap_pend set during that frame, data appears on out at the end of the following frame's COMMIT (2 frames after capture).
- disp_bank changes only on the COMMIT exit edge, simultaneously with the out update.
- Reset mid-frame aborts immediately; ram_we deasserts asynchronously. A partially written hidden bank is permitted, and the next frame rewrites it fully.
- frame_done is high exactly one cycle per frame, coincident with COMMIT.

## Test plan
Bench uses a behavioral 64x1 RAM (async read, sync write) with INIT=64'h96A5_96A5_96A5_96A5, ram address = {ram_bank, ram_addr}.
- Reset then idle 1 frame, in=16'h1234, no swap -> out=16'h96A5 at cycle 33, disp_bank=0, frame_done pulses once per 34 cycles.
- in=16'hA5C3, swap_req pulse at cycle 5 -> after first COMMIT disp_bank=1; after second COMMIT out=16'hA5C3.
- Three swap_req pulses within one frame -> exactly one disp_bank toggle at that frame's COMMIT.
- swap_req pulse during COMMIT cycle -> no toggle at that COMMIT, toggle at next COMMIT.
- Assert rst_n low during WRITE cnt=7 -> ram_we=0 immediately, out=0, disp_bank=0; after release, the full frame sequence restarts from CAPTURE.
- Count ram_we cycles per frame -> exactly IO_WIDTH. Check no access with ram_addr >= IO_WIDTH, and writes only to bank ~disp_bank.
